bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 14, binary input width (2..32).
REQ-002 SHALL have parameter DIGITS, default 4, BCD output digit count (1..10).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request conversion of value.
REQ-006 SHALL have port value  input  WIDTH  unsigned binary operand, sampled with start.
REQ-007 SHALL have port busy  output  1  conversion in progress; start ignored while high.
REQ-008 SHALL have port done  output  1  one-cycle pulse when outputs updated.
REQ-009 SHALL have port bcd  output  4*DIGITS  packed digits; digit 0 (units) in bits [3:0].
REQ-010 SHALL have port overflow  output  1  captured value exceeded 10^DIGITS-1.
REQ-011 SHALL have port lz_mask  output  DIGITS  bit i high when digit i is a leading zero (blankable).

Function
REQ-012 SHALL implement states IDLE, SHIFT, DONE; reset state IDLE.
REQ-013 SHALL, in IDLE with start=1, capture value into a shift register, clear the digit scratch register, clear the bit counter, and enter SHIFT; busy=1 from the next cycle.
REQ-014 SHALL, in SHIFT, perform exactly one double-dabble step per cycle: each scratch digit >=5 gets +3, then {scratch,shift register} shifts left by one, MSB first.
REQ-015 SHALL leave SHIFT after exactly WIDTH steps and enter DONE.
REQ-016 SHALL, on the edge entering IDLE from DONE, load bcd, overflow and lz_mask, and assert done for exactly that following cycle. busy SHALL be low in that cycle.
REQ-017 Latency SHALL be fixed: done high in the cycle after edge k+WIDTH+1, where k is the edge that sampled start.
REQ-018 SHALL accept start asserted in the done cycle (back-to-back); throughput SHALL be one conversion per WIDTH+2 cycles.
REQ-019 SHALL ignore start while busy=1; the in-flight conversion and the captured operand SHALL be unaffected.
REQ-020 SHALL compute overflow at capture as value >= 10^DIGITS. When overflow=1, bcd SHALL saturate to all digits 9.
REQ-021 SHALL size the scratch register to hold ceil(WIDTH*log10(2))+1 digits internally, so that no intermediate truncation occurs. Only the low DIGITS digits drive bcd.
REQ-022 lz_mask bit 0 SHALL always be 0. Bit i>0 SHALL be 1 iff digits i..DIGITS-1 are all zero. lz_mask SHALL be all 0 on overflow.
REQ-023 bcd, overflow and lz_mask SHALL hold their last values between done pulses and while busy.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, busy=0, done=0, bcd=0, overflow=0, lz_mask=0, and clear counter and scratch registers, independent of clk.
REQ-025 Reset during SHIFT SHALL abort the conversion with no done pulse. The first start after rst falls SHALL be handled normally.
REQ-026 No output SHALL glitch to a partial result at any time.

Structure
REQ-027 Package bin2bcd_pkg SHALL hold the state enumeration, BCD_NINE (4'h9), the add-3 threshold (4'd5), and a constant function pow10(n) used for the overflow limit and internal digit count.
REQ-028 SHALL instantiate sub-module bcd_add3_cell (4-bit in, 4-bit out, +3 if >=5) once per internal digit.
REQ-029 Bit counter width SHALL be $clog2(WIDTH+1).

Verification
REQ-030 WIDTH=14, DIGITS=4, value=1234 with a start pulse at edge k -> done in the cycle after edge k+15, bcd=16'h1234, overflow=0, lz_mask=4'b0000.
REQ-031 value=0 -> bcd=16'h0000, lz_mask=4'b1110. value=7 -> bcd=16'h0007, lz_mask=4'b1110. value=9999 -> bcd=16'h9999, overflow=0.
REQ-032 value=10000 and value=16383 -> bcd=16'h9999, overflow=1, lz_mask=0.
REQ-033 start value=42 followed by start value=77 while busy -> a single done pulse with bcd=16'h0042. start value=77 held during the done cycle -> second result 16'h0077 after WIDTH+2 cycles.
REQ-034 rst pulsed asynchronously 5 cycles into the conversion of 555 -> outputs 0 immediately and no done pulse. A following start with value=321 -> bcd=16'h0321.
REQ-035 Parameter sweep WIDTH=8/DIGITS=3 with all 256 values, and WIDTH=20/DIGITS=6 with random values -> bcd matches a decimal reference model, with done latency WIDTH+1 in every case.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// pow10() sizes both the overflow limit and the internal digit scratch register.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_NINE       = 4'h9;
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Smallest n with 10^n >= 2^width (= ceil(width*log10(2))), plus one guard digit,
    // never fewer than the number of digits presented on the output.
    function automatic int scratch_digits(input int width, input int digits);
        int n;
        n = 20;
        for (int i = 19; i >= 0; i--) begin
            if (pow10(i) >= (64'd1 << width)) begin
                n = i;
            end
        end
        n = n + 1;
        if (n < digits) begin
            n = digits;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_add3_cell
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= ADD3_THRESHOLD) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, fixed WIDTH+2 cycle throughput.
// Results are loaded into the output registers in a single edge, so outputs never show partial sums.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     lz_mask
);

    localparam int          INT_DIGITS = scratch_digits(WIDTH, DIGITS);
    localparam int          SW         = 4 * INT_DIGITS;
    localparam int          CNT_W      = $clog2(WIDTH + 1);
    localparam logic [63:0] LIMIT      = pow10(DIGITS);

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   shift_reg;
    logic [SW-1:0]      scratch_reg;
    logic [SW-1:0]      scratch_adj;
    logic [CNT_W-1:0]   cnt_reg;
    logic               ovf_reg;
    logic               last_step;
    logic [DIGITS-1:0]  lz_next;
    logic               zero_run;

    genvar gi;
    generate
        for (gi = 0; gi < INT_DIGITS; gi++) begin : g_cell
            bcd_add3_cell u_cell (
                .digit    (scratch_reg[4*gi +: 4]),
                .adjusted (scratch_adj[4*gi +: 4])
            );
        end
    endgenerate

    assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));
    assign busy      = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Leading-zero run scanned from the most significant output digit down; digit 0 never blanks.
    always_comb begin
        zero_run = 1'b1;
        lz_next  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (scratch_reg[4*i +: 4] == 4'd0);
            lz_next[i] = zero_run;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg   <= '0;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            ovf_reg     <= 1'b0;
            done        <= 1'b0;
            bcd         <= '0;
            overflow    <= 1'b0;
            lz_mask     <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shift_reg   <= value;
                        scratch_reg <= '0;
                        cnt_reg     <= '0;
                        ovf_reg     <= (64'(value) >= LIMIT);
                    end
                end
                SHIFT: begin
                    {scratch_reg, shift_reg} <= {scratch_adj, shift_reg} << 1;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                DONE: begin
                    done     <= 1'b1;
                    bcd      <= ovf_reg ? {DIGITS{BCD_NINE}} : scratch_reg[4*DIGITS-1:0];
                    overflow <= ovf_reg;
                    lz_mask  <= ovf_reg ? '0 : lz_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: three instances (14/4, 8/3, 20/6), expected results
// queued at start time and checked (value and latency) when done pulses.
module tb_bin2bcd_seq;

    typedef struct {
        logic [63:0] bcd;
        logic        ovf;
        logic [15:0] lz;
        longint      due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        start_a = 1'b0;
    logic [13:0] value_a = '0;
    logic        busy_a, done_a, ovf_a;
    logic [15:0] bcd_a;
    logic [3:0]  lz_a;

    logic        start_b = 1'b0;
    logic [7:0]  value_b = '0;
    logic        busy_b, done_b, ovf_b;
    logic [11:0] bcd_b;
    logic [2:0]  lz_b;

    logic        start_c = 1'b0;
    logic [19:0] value_c = '0;
    logic        busy_c, done_c, ovf_c;
    logic [23:0] bcd_c;
    logic [5:0]  lz_c;

    exp_t   q_a[$];
    exp_t   q_b[$];
    exp_t   q_c[$];
    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;

    bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .value(value_a), .busy(busy_a),
        .done(done_a), .bcd(bcd_a), .overflow(ovf_a), .lz_mask(lz_a)
    );
    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .value(value_b), .busy(busy_b),
        .done(done_b), .bcd(bcd_b), .overflow(ovf_b), .lz_mask(lz_b)
    );
    bin2bcd_seq #(.WIDTH(20), .DIGITS(6)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .value(value_c), .busy(busy_c),
        .done(done_c), .bcd(bcd_c), .overflow(ovf_c), .lz_mask(lz_c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Decimal reference: digits by repeated division, leading zeros by magnitude.
    function automatic exp_t model(input longint unsigned v, input int digits, input longint due);
        exp_t e;
        longint unsigned lim, p, t;
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        e.bcd = '0;
        e.lz  = '0;
        e.ovf = (v >= lim);
        e.due = due;
        t = v;
        for (int i = 0; i < digits; i++) begin
            if (e.ovf) begin
                e.bcd[4*i +: 4] = 4'h9;
            end else begin
                e.bcd[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
        p = 10;
        for (int i = 1; i < digits; i++) begin
            if (!e.ovf && v < p) e.lz[i] = 1'b1;
            p = p * 10;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done_a) begin
            checks++;
            if (q_a.size() == 0) begin
                failures++;
                $display("FAIL a_unexpected_done: got done at edge %0d, required no done", cyc);
            end else begin
                e = q_a.pop_front();
                if (bcd_a !== e.bcd[15:0] || ovf_a !== e.ovf || lz_a !== e.lz[3:0] || cyc != e.due) begin
                    failures++;
                    $display("FAIL a_result: got bcd=%h ovf=%b lz=%b edge=%0d, required bcd=%h ovf=%b lz=%b edge=%0d",
                             bcd_a, ovf_a, lz_a, cyc, e.bcd[15:0], e.ovf, e.lz[3:0], e.due);
                end else begin
                    $display("a: bcd=%h ovf=%b lz=%b edge=%0d ok", bcd_a, ovf_a, lz_a, cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done_b) begin
            checks++;
            if (q_b.size() == 0) begin
                failures++;
                $display("FAIL b_unexpected_done: got done at edge %0d, required no done", cyc);
            end else begin
                e = q_b.pop_front();
                if (bcd_b !== e.bcd[11:0] || ovf_b !== e.ovf || lz_b !== e.lz[2:0] || cyc != e.due) begin
                    failures++;
                    $display("FAIL b_result: got bcd=%h ovf=%b lz=%b edge=%0d, required bcd=%h ovf=%b lz=%b edge=%0d",
                             bcd_b, ovf_b, lz_b, cyc, e.bcd[11:0], e.ovf, e.lz[2:0], e.due);
                end else begin
                    $display("b: bcd=%h ovf=%b lz=%b edge=%0d ok", bcd_b, ovf_b, lz_b, cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done_c) begin
            checks++;
            if (q_c.size() == 0) begin
                failures++;
                $display("FAIL c_unexpected_done: got done at edge %0d, required no done", cyc);
            end else begin
                e = q_c.pop_front();
                if (bcd_c !== e.bcd[23:0] || ovf_c !== e.ovf || lz_c !== e.lz[5:0] || cyc != e.due) begin
                    failures++;
                    $display("FAIL c_result: got bcd=%h ovf=%b lz=%b edge=%0d, required bcd=%h ovf=%b lz=%b edge=%0d",
                             bcd_c, ovf_c, lz_c, cyc, e.bcd[23:0], e.ovf, e.lz[5:0], e.due);
                end else begin
                    $display("c: bcd=%h ovf=%b lz=%b edge=%0d ok", bcd_c, ovf_c, lz_c, cyc);
                end
            end
        end
    end

    // Push a hand-written expectation for instance a; the start edge is the next posedge.
    task automatic push_a(input logic [15:0] b, input logic o, input logic [3:0] l);
        exp_t e;
        e.bcd = 64'(b);
        e.ovf = o;
        e.lz  = 16'(l);
        e.due = cyc + 16;
        q_a.push_back(e);
    endtask

    task automatic wait_done_a(input string tag);
        int n;
        n = 0;
        while (!done_a && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done_a) begin
            failures++;
            $display("FAIL %s_timeout: got no done in 40 cycles, required done", tag);
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        checks += 5;
        if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy_a); end
        if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done: got %b, required 0", done_a); end
        if (bcd_a !== 16'h0) begin failures++; $display("FAIL reset_bcd: got %h, required 0000", bcd_a); end
        if (ovf_a !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b, required 0", ovf_a); end
        if (lz_a !== 4'b0) begin failures++; $display("FAIL reset_lz: got %b, required 0000", lz_a); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_known;
        logic [13:0] tv[6] = '{14'd1234, 14'd0, 14'd7, 14'd9999, 14'd10000, 14'd16383};
        logic [15:0] tb_[6] = '{16'h1234, 16'h0000, 16'h0007, 16'h9999, 16'h9999, 16'h9999};
        logic        to[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0]  tl[6]  = '{4'b0000, 4'b1110, 4'b1110, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            start_a = 1'b1;
            value_a = tv[i];
            push_a(tb_[i], to[i], tl[i]);
            @(negedge clk);
            start_a = 1'b0;
            checks++;
            if (busy_a !== 1'b1) begin failures++; $display("FAIL known_busy: got %b, required 1", busy_a); end
            repeat (15) @(negedge clk);
        end
    endtask

    task automatic test_hold;
        repeat (3) @(negedge clk);
        checks += 4;
        if (bcd_a !== 16'h9999) begin failures++; $display("FAIL hold_bcd: got %h, required 9999", bcd_a); end
        if (ovf_a !== 1'b1) begin failures++; $display("FAIL hold_ovf: got %b, required 1", ovf_a); end
        if (lz_a !== 4'b0000) begin failures++; $display("FAIL hold_lz: got %b, required 0000", lz_a); end
        if (done_a !== 1'b0) begin failures++; $display("FAIL hold_done: got %b, required 0", done_a); end
    endtask

    task automatic test_busy_ignore;
        start_a = 1'b1;
        value_a = 14'd42;
        push_a(16'h0042, 1'b0, 4'b1100);
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        checks++;
        if (bcd_a !== 16'h9999) begin failures++; $display("FAIL busy_hold_bcd: got %h, required 9999", bcd_a); end
        start_a = 1'b1;
        value_a = 14'd77;
        @(negedge clk);
        start_a = 1'b0;
        value_a = '0;
        wait_done_a("busy_ignore");
        repeat (20) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        start_a = 1'b1;
        value_a = 14'd500;
        push_a(16'h0500, 1'b0, 4'b1000);
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        wait_done_a("b2b_first");
        start_a = 1'b1;
        value_a = 14'd77;
        push_a(16'h0077, 1'b0, 4'b1100);
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        wait_done_a("b2b_second");
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        start_a = 1'b1;
        value_a = 14'd555;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks += 5;
        if (busy_a !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b, required 0", busy_a); end
        if (done_a !== 1'b0) begin failures++; $display("FAIL abort_done: got %b, required 0", done_a); end
        if (bcd_a !== 16'h0) begin failures++; $display("FAIL abort_bcd: got %h, required 0000", bcd_a); end
        if (ovf_a !== 1'b0) begin failures++; $display("FAIL abort_ovf: got %b, required 0", ovf_a); end
        if (lz_a !== 4'b0) begin failures++; $display("FAIL abort_lz: got %b, required 0000", lz_a); end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        start_a = 1'b1;
        value_a = 14'd321;
        push_a(16'h0321, 1'b0, 4'b1000);
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        wait_done_a("after_abort");
        @(negedge clk);
    endtask

    task automatic test_sweep8;
        for (int v = 0; v < 256; v++) begin
            start_b = 1'b1;
            value_b = 8'(v);
            q_b.push_back(model(longint'(v), 3, cyc + 10));
            @(negedge clk);
            start_b = 1'b0;
            repeat (9) @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_sweep20;
        logic [19:0] v;
        for (int i = 0; i < 34; i++) begin
            case (i)
                0:       v = 20'd0;
                1:       v = 20'd999999;
                2:       v = 20'd1000000;
                3:       v = 20'hFFFFF;
                default: v = 20'($urandom_range(0, 20'hFFFFF));
            endcase
            start_c = 1'b1;
            value_c = v;
            q_c.push_back(model(longint'(v), 6, cyc + 22));
            @(negedge clk);
            start_c = 1'b0;
            repeat (21) @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1000000, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_known();
        test_hold();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_sweep8();
        test_sweep20();
        repeat (5) @(negedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) begin
            failures++;
            $display("FAIL pending_results: got %0d/%0d/%0d outstanding, required 0/0/0",
                     q_a.size(), q_b.size(), q_c.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
